// File: rtl/irq_controller.sv
// Vectored interrupt controller: pending/mask/in-service registers, fixed priority with
// optional nesting, and a toggle-per-interrupt handshake towards the core.
module irq_controller #(
    parameter int unsigned CHANNELS = 8,
    parameter logic [7:0]  VBASE    = 8'd8,
    parameter logic [15:0] IO_BASE  = 16'h0020
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         port_a,
    input  logic                port_w,
    input  logic                port_r,
    input  logic [7:0]          port_o,
    output logic [7:0]          port_i,
    input  logic [CHANNELS-1:0] irq_req,
    output logic                irq,
    output logic [7:0]          irq_in
);

    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_mask;
    logic [CHANNELS-1:0] r_isr;
    logic [1:0]          r_ctrl;
    logic                r_irq;
    logic [7:0]          r_irq_in;
    logic [7:0]          r_port_i;

    logic [15:0]         w_off;
    logic                w_wr_eoi;
    logic                w_wr_mask;
    logic                w_wr_ctrl;
    logic                w_rd_hit;
    logic [7:0]          w_rd_data;

    logic [CHANNELS-1:0] w_avail;
    logic [CHANNELS-1:0] w_cand_oh;
    logic [2:0]          w_cand_idx;
    logic                w_cand_vld;
    logic [CHANNELS-1:0] w_isr_oh;
    logic [2:0]          w_isr_idx;
    logic                w_isr_vld;
    logic                w_deliver;
    logic [7:0]          w_vec;
    logic [CHANNELS-1:0] w_pend_d;
    logic [CHANNELS-1:0] w_isr_d;

    assign w_off     = port_a - IO_BASE;
    assign w_wr_eoi  = port_w && (w_off == 16'd0);
    assign w_wr_mask = port_w && (w_off == 16'd1);
    assign w_wr_ctrl = port_w && (w_off == 16'd4);

    // Offset 0 is write-only, so reads there count as undecoded.
    always_comb begin
        w_rd_hit  = port_r;
        w_rd_data = 8'h00;
        case (w_off)
            16'd1:   w_rd_data = 8'(r_mask);
            16'd2:   w_rd_data = 8'(r_pend);
            16'd3:   w_rd_data = 8'(r_isr);
            16'd4:   w_rd_data = {6'd0, r_ctrl};
            default: w_rd_hit  = 1'b0;
        endcase
    end

    assign w_avail = r_pend & ~r_mask;

    always_comb begin
        w_cand_oh  = '0;
        w_cand_idx = 3'd0;
        w_cand_vld = 1'b0;
        w_isr_oh   = '0;
        w_isr_idx  = 3'd0;
        w_isr_vld  = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!w_cand_vld && w_avail[i]) begin
                w_cand_vld   = 1'b1;
                w_cand_oh[i] = 1'b1;
                w_cand_idx   = 3'(i);
            end
            if (!w_isr_vld && r_isr[i]) begin
                w_isr_vld   = 1'b1;
                w_isr_oh[i] = 1'b1;
                w_isr_idx   = 3'(i);
            end
        end
    end

    // Nesting lets a strictly higher-priority channel pre-empt the one in service.
    assign w_deliver = r_ctrl[1] && w_cand_vld &&
                       (!w_isr_vld || (r_ctrl[0] && (w_cand_idx < w_isr_idx)));
    assign w_vec     = VBASE + {5'd0, w_cand_idx};

    // A request landing on its own delivery edge survives via the OR.
    assign w_pend_d = (r_pend & ~(w_deliver ? w_cand_oh : '0)) | irq_req;
    assign w_isr_d  = (r_isr & ~(w_wr_eoi ? w_isr_oh : '0)) | (w_deliver ? w_cand_oh : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend   <= '0;
            r_mask   <= '0;
            r_isr    <= '0;
            r_ctrl   <= 2'b10;
            r_irq    <= 1'b0;
            r_irq_in <= 8'h00;
            r_port_i <= 8'h00;
        end else begin
            r_pend <= w_pend_d;
            r_isr  <= w_isr_d;
            if (w_wr_mask) begin
                r_mask <= port_o[CHANNELS-1:0];
            end
            if (w_wr_ctrl) begin
                r_ctrl <= port_o[1:0];
            end
            if (w_deliver) begin
                r_irq    <= ~r_irq;
                r_irq_in <= w_vec;
            end
            if (w_rd_hit) begin
                r_port_i <= w_rd_data;
            end
        end
    end

    assign port_i = r_port_i;
    assign irq    = r_irq;
    assign irq_in = r_irq_in;

endmodule
